// File: rtl/instr_fetch_queue_pkg.sv
// Shared types for the instruction fetch queue: FSM states, entry payload, constants.
package fetch_pkg;

  localparam int unsigned D_WIDTH_DEF = 32;
  localparam int unsigned INST_BYTES  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [D_WIDTH_DEF-1:0] pc;
    logic [D_WIDTH_DEF-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Redirect, instruction-memory and decode-side signals of the fetch queue.
interface instr_fetch_queue_if #(
  parameter int unsigned D_WIDTH = 32
);

  logic               redirect_valid;
  logic [D_WIDTH-1:0] redirect_pc;
  logic               mem_req;
  logic [D_WIDTH-1:0] mem_addr;
  logic               mem_ready;
  logic               mem_rvalid;
  logic [D_WIDTH-1:0] mem_rdata;
  logic               inst_valid;
  logic [D_WIDTH-1:0] inst;
  logic [D_WIDTH-1:0] inst_pc;
  logic               inst_ready;

  // Fetch queue side
  modport master (
    input  redirect_valid, redirect_pc, mem_ready, mem_rvalid, mem_rdata, inst_ready,
    output mem_req, mem_addr, inst_valid, inst, inst_pc
  );

  // Memory / decode / branch-resolution side
  modport slave (
    output redirect_valid, redirect_pc, mem_ready, mem_rvalid, mem_rdata, inst_ready,
    input  mem_req, mem_addr, inst_valid, inst, inst_pc
  );

endinterface

// File: rtl/instr_fetch_queue_fifo.sv
// FIFO of {pc, inst} entries with a registered head, flush and synchronous reset.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           din,
  output logic [$clog2(DEPTH):0] count,
  output logic                   head_valid,
  output fetch_entry_t           head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;
  fetch_entry_t       head_d;

  // Next pointers/count and the entry that becomes head after this cycle
  always_comb begin
    do_push  = 1'b0;
    do_pop   = 1'b0;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      do_push  = push;
      do_pop   = pop && (count_q != '0);
      rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
    // The pushed word is the new head only when it lands in the slot being read next
    head_d = (do_push && (rd_ptr_d == wr_ptr_q)) ? din : mem_q[rd_ptr_d];
  end

  // Entry storage; contents need no reset since count gates visibility
  always_ff @(posedge CLK) begin
    if (!rst && do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointers, count and registered head; head holds its value when empty
  always_ff @(posedge CLK) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      head_valid <= 1'b0;
      head       <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      head_valid <= (count_d != '0);
      if (count_d != '0) begin
        head <= head_d;
      end
    end
  end

  assign count = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch PC owner: issues one instruction read at a time and queues returned words for decode.
// Optional macro FETCH_TRACE_EN compiles in $display tracing of pops, redirects and spurious rvalid.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned         D_WIDTH  = 32,
  parameter int unsigned         DEPTH    = 4,
  parameter logic [D_WIDTH-1:0]  RESET_PC = '0
) (
  input logic                   CLK,
  input logic                   rst,
  instr_fetch_queue_if.master   bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e       state_q, state_d;
  logic [D_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [D_WIDTH-1:0] req_pc_q, req_pc_d;
  logic               push, pop, flush, space;
  logic [CNT_W-1:0]   count;
  fetch_entry_t       push_entry, head;

  // State, fetch PC and outstanding-request PC registers
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  // Next state, request handshake and FIFO controls; redirect takes priority
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    bus.mem_req = 1'b0;
    push        = 1'b0;
    flush       = 1'b0;
    space       = (count < CNT_W'(DEPTH));
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc & ~D_WIDTH'(3);
      flush      = 1'b1;
      unique case (state_q)
        WAIT:    state_d = bus.mem_rvalid ? IDLE : DROP;
        DROP:    state_d = bus.mem_rvalid ? IDLE : DROP;
        default: state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          bus.mem_req = space && !rst;
          if (bus.mem_req && bus.mem_ready) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + D_WIDTH'(INST_BYTES);
            state_d    = WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            push    = 1'b1;
            state_d = IDLE;
          end
        end
        DROP: begin
          if (bus.mem_rvalid) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign pop           = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;
  assign push_entry.pc   = req_pc_q;
  assign push_entry.inst = bus.mem_rdata;
  assign bus.mem_addr  = fetch_pc_q & ~D_WIDTH'(3);
  assign bus.inst      = head.inst;
  assign bus.inst_pc   = head.pc;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK        (CLK),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .din        (push_entry),
    .count      (count),
    .head_valid (bus.inst_valid),
    .head       (head)
  );

`ifdef FETCH_TRACE_EN
  // Simulation trace of consumed instructions, redirects and unexpected read data
  always @(posedge CLK) begin
    if (!rst) begin
      if (bus.inst_valid && bus.inst_ready) begin
        $display("Fetch PC: %h Inst: %h", bus.inst_pc, bus.inst);
      end
      if (bus.redirect_valid) begin
        $display("Fetch redirect: old PC %h new PC %h", fetch_pc_q, bus.redirect_pc & ~D_WIDTH'(3));
      end
      if ((state_q == IDLE) && bus.mem_rvalid) begin
        $display("Fetch warning: spurious mem_rvalid in IDLE, data %h", bus.mem_rdata);
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: streaming, full FIFO, redirects, PC wrap, reset mid-request.
module tb_instr_fetch_queue;

  logic CLK;
  logic rst;
  int   errors;
  int   checks;

  instr_fetch_queue_if #(.D_WIDTH(32)) bus ();

  instr_fetch_queue #(
    .D_WIDTH  (32),
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Compare one observed value against its hand-derived expectation
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Let combinational outputs follow freshly driven inputs
  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
  endtask

  // One request accepted at address a, answered next cycle with a+0x100
  task automatic mem_txn(input logic [31:0] a);
    chk("txn_req", 32'(bus.mem_req), 32'd1);
    chk("txn_addr", bus.mem_addr, a);
    tick();
    chk("txn_wait_req", 32'(bus.mem_req), 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = a + 32'h100;
    tick();
    bus.mem_rvalid = 1'b0;
    settle();
  endtask

  initial begin
    errors             = 0;
    checks             = 0;
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.mem_ready      = 1'b0;
    bus.mem_rvalid     = 1'b0;
    bus.mem_rdata      = '0;
    bus.inst_ready     = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst", bus.inst, 32'h0);
    chk("rst_inst_pc", bus.inst_pc, 32'h0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    rst            = 1'b0;
    bus.mem_ready  = 1'b1;
    bus.inst_ready = 1'b1;
    settle();

    // Streaming with a 1-cycle memory
    mem_txn(32'h0);
    chk("s0_valid", 32'(bus.inst_valid), 32'd1);
    chk("s0_pc", bus.inst_pc, 32'h0);
    chk("s0_inst", bus.inst, 32'h100);
    mem_txn(32'h4);
    chk("s1_pc", bus.inst_pc, 32'h4);
    chk("s1_inst", bus.inst, 32'h104);
    mem_txn(32'h8);
    chk("s2_pc", bus.inst_pc, 32'h8);
    chk("s2_inst", bus.inst, 32'h108);

    // Fill to DEPTH with decode stalled, then release one entry
    bus.inst_ready = 1'b0;
    do_reset();
    mem_txn(32'h0);
    mem_txn(32'h4);
    mem_txn(32'h8);
    mem_txn(32'hC);
    chk("full_req", 32'(bus.mem_req), 32'd0);
    chk("full_head_pc", bus.inst_pc, 32'h0);
    chk("full_head_inst", bus.inst, 32'h100);
    tick();
    tick();
    chk("full_req_hold", 32'(bus.mem_req), 32'd0);
    bus.inst_ready = 1'b1;
    settle();
    tick();
    bus.inst_ready = 1'b0;
    settle();
    chk("pop1_req", 32'(bus.mem_req), 32'd1);
    chk("pop1_addr", bus.mem_addr, 32'h10);
    chk("pop1_head_pc", bus.inst_pc, 32'h4);
    mem_txn(32'h10);
    chk("refill_valid", 32'(bus.inst_valid), 32'd1);

    // Redirect while waiting; stale data arrives two cycles later
    do_reset();
    mem_txn(32'h0);
    chk("rw_req", 32'(bus.mem_req), 32'd1);
    chk("rw_addr", bus.mem_addr, 32'h4);
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h203;
    settle();
    chk("rw_req_during", 32'(bus.mem_req), 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    settle();
    chk("rw_flushed", 32'(bus.inst_valid), 32'd0);
    chk("rw_drop_req", 32'(bus.mem_req), 32'd0);
    tick();
    chk("rw_drop_req2", 32'(bus.mem_req), 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD;
    tick();
    bus.mem_rvalid = 1'b0;
    settle();
    chk("rw_discard", 32'(bus.inst_valid), 32'd0);
    chk("rw_next_req", 32'(bus.mem_req), 32'd1);
    chk("rw_next_addr", bus.mem_addr, 32'h200);

    // Redirect in the same cycle as read data
    bus.inst_ready = 1'b1;
    tick();
    bus.mem_rvalid     = 1'b1;
    bus.mem_rdata      = 32'h1234;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    settle();
    tick();
    bus.mem_rvalid     = 1'b0;
    bus.redirect_valid = 1'b0;
    settle();
    chk("rs_dropped", 32'(bus.inst_valid), 32'd0);
    chk("rs_req", 32'(bus.mem_req), 32'd1);
    chk("rs_addr", bus.mem_addr, 32'h40);
    tick();
    chk("rs_still_empty", 32'(bus.inst_valid), 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5555;
    tick();
    bus.mem_rvalid = 1'b0;
    settle();
    chk("rs_valid", 32'(bus.inst_valid), 32'd1);
    chk("rs_pc", bus.inst_pc, 32'h40);
    chk("rs_inst", bus.inst, 32'h5555);

    // Redirect in IDLE to the top word, then PC wrap
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    settle();
    chk("wr_req_blocked", 32'(bus.mem_req), 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    settle();
    chk("wr_flushed", 32'(bus.inst_valid), 32'd0);
    chk("wr_req", 32'(bus.mem_req), 32'd1);
    chk("wr_addr", bus.mem_addr, 32'hFFFF_FFFC);
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hABCD;
    tick();
    bus.mem_rvalid = 1'b0;
    settle();
    chk("wr_pc", bus.inst_pc, 32'hFFFF_FFFC);
    chk("wr_inst", bus.inst, 32'hABCD);
    chk("wr_wrap_req", 32'(bus.mem_req), 32'd1);
    chk("wr_wrap_addr", bus.mem_addr, 32'h0);

    // Reset while waiting with two queued entries; late data ignored
    bus.inst_ready = 1'b0;
    do_reset();
    mem_txn(32'h0);
    mem_txn(32'h4);
    chk("rr_addr", bus.mem_addr, 32'h8);
    tick();
    chk("rr_valid_before", 32'(bus.inst_valid), 32'd1);
    chk("rr_pc_before", bus.inst_pc, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("rr_valid", 32'(bus.inst_valid), 32'd0);
    chk("rr_inst", bus.inst, 32'h0);
    chk("rr_inst_pc", bus.inst_pc, 32'h0);
    chk("rr_req", 32'(bus.mem_req), 32'd1);
    chk("rr_addr_reset", bus.mem_addr, 32'h0);
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hBAD;
    tick();
    bus.mem_rvalid = 1'b0;
    settle();
    chk("late_ignored", 32'(bus.inst_valid), 32'd0);
    chk("late_req", 32'(bus.mem_req), 32'd1);
    chk("late_addr", bus.mem_addr, 32'h0);
    bus.mem_ready = 1'b1;
    settle();
    mem_txn(32'h0);
    chk("post_valid", 32'(bus.inst_valid), 32'd1);
    chk("post_pc", bus.inst_pc, 32'h0);
    chk("post_inst", bus.inst, 32'h100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
